fp_cmp_arbiter: RTL and testbench
=================================

Name: fp_cmp_arbiter

Overview:
Shares one 13-bit floating-point "greater-than" comparator among NUM_REQ requesters. It uses a round-robin arbiter and a 2-stage pipeline: grant/operand capture, then compare/result register. Results return on a single valid/ready channel tagged with the requester ID. It sits between multiple sort/threshold engines and the compare datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester request; held with operands until granted
i_opa  in  NUM_REQ*13  operand A per requester, slice k = [13k+12:13k]
i_opb  in  NUM_REQ*13  operand B per requester, same slicing
o_gnt  out  NUM_REQ  one-hot grant, combinational; operands captured at this clock edge
o_valid  out  1  result valid
o_id  out  ID_W  requester ID of the result
o_gt  out  1  1 iff A > B strictly
i_ready  in  1  result consumer ready

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Number format: bit12 sign (1 = negative); [11:8] unsigned exponent e; [7:0] mantissa m; value = (-1)^s * 0.m * 2^e.
- Magnitude zero iff m == 0, whatever the exponent. +0 and -0 compare equal.
- Magnitude order: a zero magnitude is below any nonzero one. Otherwise compare e, then m, unsigned.
- Sign rules: both nonnegative -> larger magnitude is greater. Both negative -> smaller magnitude is greater. Mixed signs -> nonzero positive > negative. Zero vs zero -> equal. Equal values -> o_gt = 0.
- Reset values: o_valid = 0, o_id = 0, o_gt = 0, o_gnt = 0, RR pointer = 0, S1 valid = 0, S1 operands = 0.
- Stage S1 (operand regs): s1_vld, s1_id, s1_a, s1_b.
- Output stage: o_valid, o_id, o_gt.
- out_adv = !o_valid | i_ready.
- s1_free = !s1_vld | out_adv.
- Grant: when s1_free and |i_req, grant the first set i_req at or after the pointer, wrapping modulo NUM_REQ. o_gnt is one-hot and drives no other state. With no grant, o_gnt = 0.
- On a granted edge: capture the winner's operands and ID into S1, set s1_vld = 1, and set pointer = winner+1 mod NUM_REQ. With no grant, the pointer holds.
- When s1_free and no request: s1_vld <= 0 if out_adv.
- On out_adv: o_valid <= s1_vld, and o_id / o_gt <= S1 ID / compare result. The compare is combinational on S1 registers.
- Latency: grant in cycle t -> o_valid in t+2 with an idle pipeline. Throughput is 1 compare/cycle when i_ready = 1.
- Backpressure: while o_valid && !i_ready, o_id/o_gt stay stable and the output holds. S1 may fill once; after that o_gnt = 0 until i_ready.
- Simultaneous events: the output is consumed and a new S1 entry moves in on the same edge. A request may drop after its grant cycle; a request dropped before its grant is simply not served.
- Reset mid-operation clears all in-flight entries. No result is emitted for requests granted before reset.

Optional Feature:
FP_CMP_ARB_EQ_EN
- Defined: adds output o_eq (1 bit, reset 0), registered alongside o_gt. o_eq = 1 iff A == B under the rules above, so +0 == -0 and all zero-mantissa encodings are equal. o_gt and o_eq are never both 1.
- Undefined: the o_eq port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package fp13_pkg holds:
  - FP_W = 13, EXP_W = 4, MAN_W = 8 and the field index constants;
  - typedef fp13_t (packed struct sign/exp/man);
  - function fp13_is_zero.
- One sub-module, fp13_gt_cmp: purely combinational, inputs a and b, outputs gt (and eq under the macro). Instantiated once, on the S1 registers.
- The arbiter pointer/priority logic stays inline.

Test Plan:
- Basic compare, NUM_REQ=4: req0 with A=0x0180 (+1.0), B=0x01F0 (+1.875). Expect o_gnt=0001 in cycle t; o_valid=1, o_id=0, o_gt=0 in t+2.
- Sign case: req2 with A=0x0180, B=0x11F0 (-1.875). Expect o_gnt=0100, then o_id=2, o_gt=1. Swapping the operands gives o_gt=0.
- Round-robin: all four reqs held from reset, i_ready=1. Expect grants 0,1,2,3,0 on consecutive cycles and results in the same ID order, one per cycle.
- Backpressure: i_ready=0 for 4 cycles with all reqs pending. Expect o_valid, o_id and o_gt stable; exactly one further grant (S1 fill), then o_gnt=0. On i_ready=1, streaming resumes with no loss or duplication.
- Zero/equality: A=0x0000 vs B=0x1000, A=0x0F00 vs B=0x0000, and A=0x01F0 vs B=0x01F0. Expect o_gt=0 for all three; o_eq=1 for all three with FP_CMP_ARB_EQ_EN.
- Reset mid-operation: drop i_rst_n while S1 and output are both valid. Expect o_valid=0, o_gnt=0 and pointer=0 immediately. After release, req3 alone is granted first with o_id=3.

Source files
------------

// File: rtl/fp13_pkg.sv
// 13-bit floating-point format shared by the compare arbiter: sign, 4-bit exponent, 8-bit mantissa.
// Value = (-1)^sign * 0.man * 2^exp; any encoding with man == 0 is zero.
package fp13_pkg;

   localparam int FP_W  = 13;
   localparam int EXP_W = 4;
   localparam int MAN_W = 8;

   localparam int SIGN_BIT = 12;
   localparam int EXP_MSB  = 11;
   localparam int EXP_LSB  = 8;
   localparam int MAN_MSB  = 7;
   localparam int MAN_LSB  = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp13_t;

   function automatic logic fp13_is_zero(input fp13_t v);
      return (v.man == '0);
   endfunction

endpackage

// File: rtl/fp13_gt_cmp.sv
// Combinational strict greater-than for fp13 values; with FP_CMP_ARB_EQ_EN also reports equality.
// Zeros of either sign and any exponent compare equal and sit between the negatives and the positives.
module fp13_gt_cmp
   import fp13_pkg::*;
(
   input  fp13_t a,
   input  fp13_t b,
   output logic  gt
`ifdef FP_CMP_ARB_EQ_EN
   ,
   output logic  eq
`endif
);

   logic za, zb;
   logic a_neg, b_neg;
   logic a_mag_gt, b_mag_gt;

   assign za = fp13_is_zero(a);
   assign zb = fp13_is_zero(b);

   // A zero magnitude counts as nonnegative, so -0 behaves exactly like +0.
   assign a_neg = a.sign & ~za;
   assign b_neg = b.sign & ~zb;

   assign a_mag_gt = !za && (zb || ({a.exp, a.man} > {b.exp, b.man}));
   assign b_mag_gt = !zb && (za || ({b.exp, b.man} > {a.exp, a.man}));

   assign gt = (a_neg == b_neg) ? (a_neg ? b_mag_gt : a_mag_gt) : b_neg;

`ifdef FP_CMP_ARB_EQ_EN
   assign eq = (za && zb) || (!za && !zb && (a == b));
`endif

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Round-robin sharing of one fp13 greater-than comparator across NUM_REQ requesters, 2-stage pipeline.
// Optional o_eq result output is enabled by defining FP_CMP_ARB_EQ_EN.
module fp_cmp_arbiter
   import fp13_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_REQ-1:0]      i_req,
   input  logic [NUM_REQ*FP_W-1:0] i_opa,
   input  logic [NUM_REQ*FP_W-1:0] i_opb,
   output logic [NUM_REQ-1:0]      o_gnt,
   output logic                    o_valid,
   output logic [ID_W-1:0]         o_id,
   output logic                    o_gt,
`ifdef FP_CMP_ARB_EQ_EN
   output logic                    o_eq,
`endif
   input  logic                    i_ready
);

   // Handshake: a result transfers on any edge where o_valid && i_ready; while o_valid is high
   // and i_ready low, o_id/o_gt hold. A requester transfers its operands on the edge where its
   // o_gnt bit is high and must hold i_req plus operands stable until then.

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] ptr_nxt;
   logic            win_any;
   logic            grant_en;
   int              idx;

   logic            s1_vld;
   logic [ID_W-1:0] s1_id;
   fp13_t           s1_a;
   fp13_t           s1_b;

   logic            out_adv;
   logic            s1_free;
   logic            cmp_gt;
`ifdef FP_CMP_ARB_EQ_EN
   logic            cmp_eq;
`endif

   assign out_adv = !o_valid || i_ready;
   assign s1_free = !s1_vld || out_adv;

   // Scan from the pointer upward, wrapping; the first pending request wins.
   always_comb begin
      win_any = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!win_any && i_req[idx]) begin
            win_any = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   assign grant_en = i_rst_n && s1_free && win_any;
   assign o_gnt    = grant_en ? (NUM_REQ'(1) << win_id) : '0;
   assign ptr_nxt  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr    <= '0;
         s1_vld <= 1'b0;
         s1_id  <= '0;
         s1_a   <= '0;
         s1_b   <= '0;
      end else if (grant_en) begin
         ptr    <= ptr_nxt;
         s1_vld <= 1'b1;
         s1_id  <= win_id;
         s1_a   <= fp13_t'(i_opa[int'(win_id)*FP_W +: FP_W]);
         s1_b   <= fp13_t'(i_opb[int'(win_id)*FP_W +: FP_W]);
      end else if (out_adv) begin
         s1_vld <= 1'b0;
      end
   end

   fp13_gt_cmp u_cmp (
      .a  (s1_a),
      .b  (s1_b),
`ifdef FP_CMP_ARB_EQ_EN
      .eq (cmp_eq),
`endif
      .gt (cmp_gt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_id    <= '0;
         o_gt    <= 1'b0;
`ifdef FP_CMP_ARB_EQ_EN
         o_eq    <= 1'b0;
`endif
      end else if (out_adv) begin
         o_valid <= s1_vld;
         o_id    <= s1_id;
         o_gt    <= cmp_gt;
`ifdef FP_CMP_ARB_EQ_EN
         o_eq    <= cmp_eq;
`endif
      end
   end

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Self-checking bench for fp_cmp_arbiter: directed cases plus randomized traffic against a queue-based model.
// Compile with FP_CMP_ARB_EQ_EN defined to also check o_eq.
module tb_fp_cmp_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req   = '0;
   logic [N*13-1:0] opa   = '0;
   logic [N*13-1:0] opb   = '0;
   logic            ready = 1'b1;
   logic [N-1:0]    gnt;
   logic            valid;
   logic [IW-1:0]   id;
   logic            gt;
`ifdef FP_CMP_ARB_EQ_EN
   logic            eq;
`endif

   fp_cmp_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_opa   (opa),
      .i_opb   (opb),
      .o_gnt   (gnt),
      .o_valid (valid),
      .o_id    (id),
      .o_gt    (gt),
`ifdef FP_CMP_ARB_EQ_EN
      .o_eq    (eq),
`endif
      .i_ready (ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Ordering key: zero is 0, nonzero magnitudes rank by exponent then mantissa, negatives mirrored.
   function automatic int fp_key(input logic [12:0] v);
      int k;
      if (v[7:0] == 8'd0) return 0;
      k = int'(v[11:8]) * 256 + int'(v[7:0]);
      return v[12] ? -k : k;
   endfunction

   function automatic bit model_gt(input logic [12:0] a, input logic [12:0] b);
      return fp_key(a) > fp_key(b);
   endfunction

   function automatic bit model_eq(input logic [12:0] a, input logic [12:0] b);
      return fp_key(a) == fp_key(b);
   endfunction

   typedef struct {
      int id;
      bit gt;
      bit eq;
      int cyc;
   } ent_t;

   ent_t exp_q[$];
   int   m_ptr = 0;
   int   cyc   = 0;
   bit   ev, consume, free;
   int   win;
   ent_t e;

   // The pipeline holds at most two results; a granted entry appears at the output two cycles later
   // and leaves on the first cycle it is presented with ready high.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ptr = 0;
         check("rst_valid", int'(valid), 0);
         check("rst_gnt", int'(gnt), 0);
      end else begin
         ev = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
         check("valid", int'(valid), int'(ev));
         if (ev) begin
            check("id", int'(id), exp_q[0].id);
            check("gt", int'(gt), int'(exp_q[0].gt));
`ifdef FP_CMP_ARB_EQ_EN
            check("eq", int'(eq), int'(exp_q[0].eq));
`endif
         end
         consume = ev && ready;
         free    = (exp_q.size() < 2) || consume;
         win     = -1;
         if (free) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
         end
         check("gnt", int'(gnt), (win >= 0) ? (1 << win) : 0);
         if (consume) void'(exp_q.pop_front());
         if (win >= 0) begin
            e.id  = win;
            e.gt  = model_gt(opa[win*13 +: 13], opb[win*13 +: 13]);
            e.eq  = model_eq(opa[win*13 +: 13], opb[win*13 +: 13]);
            e.cyc = cyc;
            exp_q.push_back(e);
            m_ptr = (win + 1) % N;
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [12:0] rand_fp();
      logic [12:0] v;
      v = 13'($urandom_range(0, 8191));
      case ($urandom_range(0, 3))
         0: v[7:0] = 8'd0;
         1: v[11:8] = 4'($urandom_range(0, 1));
         default: ;
      endcase
      return v;
   endfunction

   task automatic set_ops(input int k, input logic [12:0] a, input logic [12:0] b);
      opa[k*13 +: 13] = a;
      opb[k*13 +: 13] = b;
   endtask

   // Starts right after a clock edge with an idle pipeline and returns right after an edge, idle again.
   task automatic single_req(input int k, input logic [12:0] a, input logic [12:0] b,
                             input bit egt, input bit eeq);
      set_ops(k, a, b);
      req   = N'(1) << k;
      ready = 1'b1;
      @(negedge clk);
      check("lit_gnt", int'(gnt), 1 << k);
      next_cycle(1);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      check("lit_valid", int'(valid), 1);
      check("lit_id", int'(id), k);
      check("lit_gt", int'(gt), int'(egt));
`ifdef FP_CMP_ARB_EQ_EN
      check("lit_eq", int'(eq), int'(eeq));
`else
      if (eeq != model_eq(a, b)) check("lit_eq_model", int'(model_eq(a, b)), int'(eeq));
`endif
      next_cycle(1);
   endtask

   int n_gnt;
   logic [N-1:0] g;

   initial begin
      // Pin the model with hand-computed results.
      check("pin_pos", int'(model_gt(13'h0180, 13'h01F0)), 0);
      check("pin_mix", int'(model_gt(13'h0180, 13'h11F0)), 1);
      check("pin_zero", int'(model_eq(13'h0F00, 13'h1000)), 1);
      check("pin_neg", int'(model_gt(13'h1180, 13'h11F0)), 1);

      // Round-robin with all requests held from reset.
      for (int k = 0; k < N; k++) set_ops(k, rand_fp(), rand_fp());
      req   = '1;
      ready = 1'b1;
      next_cycle(3);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_gnt", int'(gnt), 1 << (i % N));
      end
      next_cycle(1);
      req = '0;
      next_cycle(4);

      // Basic, sign and zero/equality cases.
      single_req(0, 13'h0180, 13'h01F0, 1'b0, 1'b0);
      single_req(2, 13'h0180, 13'h11F0, 1'b1, 1'b0);
      single_req(2, 13'h11F0, 13'h0180, 1'b0, 1'b0);
      single_req(1, 13'h0000, 13'h1000, 1'b0, 1'b1);
      single_req(1, 13'h0F00, 13'h0000, 1'b0, 1'b1);
      single_req(1, 13'h01F0, 13'h01F0, 1'b0, 1'b1);

      // Backpressure: one result parked at the output, S1 empty, all requests pending.
      ready = 1'b0;
      set_ops(0, 13'h0280, 13'h0180);
      req = 4'b0001;
      next_cycle(1);
      req = '0;
      next_cycle(1);
      for (int k = 0; k < N; k++) set_ops(k, rand_fp(), rand_fp());
      req   = '1;
      n_gnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (gnt != '0) n_gnt++;
         check("bp_valid", int'(valid), 1);
         check("bp_id", int'(id), 0);
         check("bp_gt", int'(gt), 1);
      end
      check("bp_grants", n_gnt, 1);
      next_cycle(1);
      ready = 1'b1;
      next_cycle(8);
      req = '0;
      next_cycle(4);

      // Reset with both stages full and the pointer moved away from zero.
      ready = 1'b0;
      req   = '1;
      next_cycle(3);
      rst_n = 1'b0;
      #1;
      check("arst_valid", int'(valid), 0);
      check("arst_gnt", int'(gnt), 0);
      next_cycle(2);
      req   = 4'b0110;
      ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_ptr", int'(gnt), 4'b0010);
      next_cycle(1);
      req = '0;
      next_cycle(4);
      single_req(3, 13'h0380, 13'h0381, 1'b0, 1'b0);

      // Randomized traffic with random backpressure and occasional abandoned requests.
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         g = gnt;
         next_cycle(1);
         for (int k = 0; k < N; k++) begin
            if (req[k] && g[k]) req[k] = 1'b0;
            else if (req[k] && g == '0 && $urandom_range(0, 15) == 0) req[k] = 1'b0;
            if (!req[k] && $urandom_range(0, 2) == 0) begin
               set_ops(k, rand_fp(), ($urandom_range(0, 4) == 0) ? opa[k*13 +: 13] : rand_fp());
               req[k] = 1'b1;
            end
         end
         ready = ($urandom_range(0, 3) != 0);
      end
      req   = '0;
      ready = 1'b1;
      next_cycle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
